// File: rtl/centroid_pkg.sv
// centroid_pkg: shared constants and the controller state type for the
// centroid/bounding-box tracker.
package centroid_pkg;

  localparam int COORD_W  = 10;  // pixel coordinate width
  localparam int SUM_W    = 28;  // coordinate-sum width (covers a full 640x480 frame)
  localparam int CNT_W    = 19;  // mask pixel count width
  localparam int DIV_ITER = 28;  // restoring-divider iterations, one per dividend bit

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    DIV_X   = 2'd1,
    DIV_Y   = 2'd2,
    PUBLISH = 2'd3
  } ct_state_t;

endpackage

// File: rtl/seq_divider.sv
// seq_divider: unsigned restoring divider, SUM_W-bit dividend by CNT_W-bit
// divisor, one quotient bit per cycle.
//   clk, rst         : clock, synchronous active-high reset
//   start            : one-cycle pulse, latches dividend/divisor
//   dividend/divisor : operands sampled on start
//   done             : one-cycle pulse; quotient is final in that cycle
//   busy             : iterations in progress
//   quotient         : low COORD_W bits of the quotient
// Timing: start in cycle s, iterations in s+1..s+DIV_ITER, done in s+DIV_ITER+1.
// A zero divisor always "fits", so the quotient comes out all ones.
module seq_divider
  import centroid_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [SUM_W-1:0]   dividend,
  input  logic [CNT_W-1:0]   divisor,
  output logic               done,
  output logic               busy,
  output logic [COORD_W-1:0] quotient
);

  localparam int ITER_W = $clog2(DIV_ITER + 1);

  logic [SUM_W-1:0]  quot;
  logic [CNT_W-1:0]  rem;
  logic [CNT_W-1:0]  dvsr;
  logic [ITER_W-1:0] iter;

  // One restoring step: shift the next dividend bit into the remainder and
  // subtract the divisor when it fits.
  logic [CNT_W:0]   shifted;
  logic [CNT_W-1:0] diff;
  logic             fits;

  assign shifted = {rem, quot[SUM_W-1]};
  assign fits    = shifted >= {1'b0, dvsr};
  assign diff    = CNT_W'(shifted - {1'b0, dvsr});

  always_ff @(posedge clk) begin
    if (rst) begin
      quot <= '0;
      rem  <= '0;
      dvsr <= '0;
      iter <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        quot <= dividend;
        rem  <= '0;
        dvsr <= divisor;
        iter <= ITER_W'(DIV_ITER);
        busy <= 1'b1;
      end else if (busy) begin
        quot <= {quot[SUM_W-2:0], fits};
        rem  <= fits ? diff : shifted[CNT_W-1:0];
        iter <= iter - ITER_W'(1);
        if (iter == ITER_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient = quot[COORD_W-1:0];

endmodule

// File: rtl/centroid_tracker.sv
// centroid_tracker: accumulates mask pixel count, coordinate sums and
// extremes over a raster frame, then divides with one shared sequential
// divider and publishes the centroid and bounding box for the next frame.
//   clk, rst          : pixel clock, synchronous active-high reset
//   enable            : low -> mask ignored (frame-end processing still runs)
//   draw_x/draw_y/vde : raster position and active-video qualifier
//   mask_in           : current pixel is target
//   centroid_x/y, centroid_valid, bbox_* : published result, change only
//                       in the PUBLISH cycle
//   update            : one-cycle pulse in the PUBLISH cycle
//   busy              : a frame result is being computed
//   overrun           : sticky; a frame end arrived while busy
// Build option: define CENTROID_BBOX_EN to build the min/max trackers;
// otherwise the four bbox outputs are constant 0.
// Latency: frame end sampled in cycle T -> busy from T+1, update at T+60,
// busy low at T+61 (X division T+1..T+30, Y division chained T+30..T+59).
module centroid_tracker
  import centroid_pkg::*;
#(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int MIN_PIXELS   = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [COORD_W-1:0] draw_x,
  input  logic [COORD_W-1:0] draw_y,
  input  logic               vde,
  input  logic               mask_in,
  output logic [COORD_W-1:0] centroid_x,
  output logic [COORD_W-1:0] centroid_y,
  output logic               centroid_valid,
  output logic [COORD_W-1:0] bbox_min_x,
  output logic [COORD_W-1:0] bbox_min_y,
  output logic [COORD_W-1:0] bbox_max_x,
  output logic [COORD_W-1:0] bbox_max_y,
  output logic               update,
  output logic               busy,
  output logic               overrun
);

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(FRAME_WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(FRAME_HEIGHT - 1);

  ct_state_t          state, state_next;
  logic               hit, frame_end, snap_take, kick;
  logic               x_done, publish_load, count_ok;
  logic               div_start, div_done, div_busy;
  logic [SUM_W-1:0]   div_dividend;
  logic [COORD_W-1:0] div_quot, quot_x;

  logic [CNT_W-1:0]   acc_cnt, snap_cnt, cnt_in;
  logic [SUM_W-1:0]   acc_sx, acc_sy, snap_sx, snap_sy, sx_in, sy_in;

  assign hit       = vde & enable & mask_in;
  assign frame_end = vde && (draw_x == X_LAST) && (draw_y == Y_LAST);

  // Accumulator values including the current pixel; the frame-end pixel
  // belongs to the frame being closed, so the snapshot takes these.
  assign cnt_in = acc_cnt + CNT_W'(hit);
  assign sx_in  = acc_sx + (hit ? SUM_W'(draw_x) : '0);
  assign sy_in  = acc_sy + (hit ? SUM_W'(draw_y) : '0);

  always_ff @(posedge clk) begin
    if (rst || frame_end) begin
      acc_cnt <= '0;
      acc_sx  <= '0;
      acc_sy  <= '0;
    end else begin
      acc_cnt <= cnt_in;
      acc_sx  <= sx_in;
      acc_sy  <= sy_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snap_cnt <= '0;
      snap_sx  <= '0;
      snap_sy  <= '0;
    end else if (snap_take) begin
      snap_cnt <= cnt_in;
      snap_sx  <= sx_in;
      snap_sy  <= sy_in;
    end
  end

  // Controller. kick marks the first DIV_X cycle so the X division starts
  // there; the Y division is started in the X done cycle so both fit the
  // fixed 60-cycle budget.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
      kick  <= 1'b0;
    end else begin
      state <= state_next;
      kick  <= snap_take;
    end
  end

  always_comb begin
    state_next   = state;
    snap_take    = 1'b0;
    div_start    = 1'b0;
    div_dividend = snap_sx;
    case (state)
      ACCUM: begin
        if (frame_end) begin
          snap_take  = 1'b1;
          state_next = DIV_X;
        end
      end
      DIV_X: begin
        if (kick) div_start = 1'b1;
        if (div_done) begin
          div_start    = 1'b1;
          div_dividend = snap_sy;
          state_next   = DIV_Y;
        end
      end
      DIV_Y: begin
        if (div_done) state_next = PUBLISH;
      end
      PUBLISH: state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  seq_divider u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (snap_cnt),
    .done     (div_done),
    .busy     (div_busy),
    .quotient (div_quot)
  );

  assign x_done       = (state == DIV_X) && div_done;
  assign publish_load = (state == DIV_Y) && div_done;
  assign count_ok     = snap_cnt >= CNT_W'(MIN_PIXELS);

  // Outputs load on the edge into PUBLISH so they are visible with update.
  always_ff @(posedge clk) begin
    if (rst) begin
      quot_x         <= '0;
      centroid_x     <= '0;
      centroid_y     <= '0;
      centroid_valid <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      if (x_done) quot_x <= div_quot;
      if (publish_load) begin
        centroid_valid <= count_ok;
        if (count_ok) begin
          centroid_x <= quot_x;
          centroid_y <= div_quot;
        end
      end
      if (frame_end && (state != ACCUM)) overrun <= 1'b1;
    end
  end

  assign update = (state == PUBLISH);
  assign busy   = (state != ACCUM) | div_busy;

`ifdef CENTROID_BBOX_EN
  logic [COORD_W-1:0] min_x, min_y, max_x, max_y;
  logic [COORD_W-1:0] min_x_in, min_y_in, max_x_in, max_y_in;
  logic [COORD_W-1:0] snap_min_x, snap_min_y, snap_max_x, snap_max_y;

  assign min_x_in = (hit && (draw_x < min_x)) ? draw_x : min_x;
  assign min_y_in = (hit && (draw_y < min_y)) ? draw_y : min_y;
  assign max_x_in = (hit && (draw_x > max_x)) ? draw_x : max_x;
  assign max_y_in = (hit && (draw_y > max_y)) ? draw_y : max_y;

  always_ff @(posedge clk) begin
    if (rst || frame_end) begin
      min_x <= X_LAST;
      min_y <= Y_LAST;
      max_x <= '0;
      max_y <= '0;
    end else begin
      min_x <= min_x_in;
      min_y <= min_y_in;
      max_x <= max_x_in;
      max_y <= max_y_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snap_min_x <= '0;
      snap_min_y <= '0;
      snap_max_x <= '0;
      snap_max_y <= '0;
    end else if (snap_take) begin
      snap_min_x <= min_x_in;
      snap_min_y <= min_y_in;
      snap_max_x <= max_x_in;
      snap_max_y <= max_y_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bbox_min_x <= '0;
      bbox_min_y <= '0;
      bbox_max_x <= '0;
      bbox_max_y <= '0;
    end else if (publish_load && count_ok) begin
      bbox_min_x <= snap_min_x;
      bbox_min_y <= snap_min_y;
      bbox_max_x <= snap_max_x;
      bbox_max_y <= snap_max_y;
    end
  end
`else
  assign bbox_min_x = '0;
  assign bbox_min_y = '0;
  assign bbox_max_x = '0;
  assign bbox_max_y = '0;
`endif

endmodule

// File: doc/centroid_tracker.md
# centroid_tracker

Producer side of the centroid/bounding-box interface consumed by the overlay stage. Scans a per-pixel binary target mask in raster order and accumulates pixel count, coordinate sums and extremes over one frame. At frame end it snapshots the accumulators and divides the sums by the count with a shared sequential divider. It then publishes `centroid_x/y`, `centroid_valid` and the bbox corners, which stay stable for the whole next frame.

## Interface
- `FRAME_WIDTH`, 640: active pixels per line.
- `FRAME_HEIGHT`, 480: active lines per frame.
- `MIN_PIXELS`, 64: minimum mask count for a valid result.

Ports:
- `clk` in 1: pixel clock; the only clock.
- `rst` in 1: reset, synchronous, active-high.
- `enable` in 1: when low, the mask is ignored and contributes nothing.
- `draw_x` in 10: current pixel column.
- `draw_y` in 10: current pixel row.
- `vde` in 1: active-video qualifier.
- `mask_in` in 1: current pixel is target.
- `centroid_x` out 10: published centroid column.
- `centroid_y` out 10: published centroid row.
- `centroid_valid` out 1: the published result meets `MIN_PIXELS`.
- `bbox_min_x`, `bbox_min_y`, `bbox_max_x`, `bbox_max_y` out 10 each: published bounding box.
- `update` out 1: one-cycle pulse when the outputs change.
- `busy` out 1: a division is in progress.
- `overrun` out 1: sticky; a frame end arrived while busy.

## Operation
- Hit condition: `vde && enable && mask_in`.
  - On a hit: `count += 1`, `sum_x += draw_x`, `sum_y += draw_y`, and min/max of x and y are updated.
- Frame end is the cycle with `vde && draw_x==FRAME_WIDTH-1 && draw_y==FRAME_HEIGHT-1`.
  - The pixel of that cycle is included in the snapshot.
  - Accumulators clear on the same edge: count and sums to 0, mins to `FRAME_WIDTH-1`/`FRAME_HEIGHT-1`, maxes to 0.
- FSM states:
  - ACCUM: idle, `busy`=0. On frame end: snapshot, go to DIV_X.
  - DIV_X: one-cycle divider start with `sum_x/count`; wait for done, then go to DIV_Y.
  - DIV_Y: the same with `sum_y/count`; on done, go to PUBLISH.
  - PUBLISH: one cycle, then back to ACCUM.
- PUBLISH action:
  - `update`=1.
  - If snapshot count >= `MIN_PIXELS`: load the centroid and bbox outputs and set `centroid_valid`=1.
  - Otherwise: `centroid_valid`=0 and coordinate/bbox outputs hold their previous values.
- Divide-by-zero (count 0): the path still runs for fixed latency; the quotient is discarded because of the count check.
- Arithmetic:
  - Sums are 28 bits unsigned; count is 19 bits.
  - Quotient is truncated toward zero and taken as its low 10 bits; it never exceeds the frame bound.
- Frame end while not in ACCUM:
  - Accumulators still clear.
  - The snapshot is not taken; that frame is lost.
  - `overrun` is set and stays set until `rst`.
- `enable` low: accumulation stops, but frame-end processing still occurs. The result is `centroid_valid`=0.

## Timing
- Reset value of every output is 0.
  - Applies to centroid, bbox, `centroid_valid`, `update`, `busy` and `overrun`.
  - Internal state goes to ACCUM with accumulators in the cleared state.
- Frame-end sample at cycle T:
  - Snapshot is registered and `busy` rises at T+1.
  - Each division takes 28 iterations plus start/done overhead.
  - `update` is high exactly at cycle T+60, and the new outputs are visible from T+60.
  - `busy` falls at T+61.
- Latency is fixed regardless of count.
- `rst` mid-division aborts the division: no `update` pulse, and all outputs return to reset values on that edge.
- Outputs change only in the PUBLISH cycle, so they are stable for the whole frame (blanking is more than 60 cycles).

## Configuration
- `CENTROID_BBOX_EN` defined: min/max trackers and snapshot registers are built, and bbox outputs are published as described.
- Not defined: those registers are omitted and all four bbox outputs are constant 0.
  - Centroid, valid, `update` and latency are unchanged.

## Structure
- `centroid_pkg`:
  - Constants `COORD_W`=10, `SUM_W`=28, `CNT_W`=19, `DIV_ITER`=28.
  - State enum `ct_state_t` (ACCUM, DIV_X, DIV_Y, PUBLISH).
- Sub-module `seq_divider`:
  - Restoring divider, unsigned, `SUM_W` dividend by `CNT_W` divisor.
  - Ports: `start`, `done`, `busy`, `quotient`.
  - Divisor 0 yields an all-ones quotient.
  - Instantiated once and shared between x and y.

## Test plan
- Single hit at (100,50), `MIN_PIXELS`=1 -> `update` at T+60; centroid (100,50), bbox x 100..100, y 50..50, valid=1.
- Filled rectangle x 200..209, y 100..119 (200 pixels) -> centroid (204,109) truncated; bbox (200,100)-(209,119); valid=1.
- 63 hits with `MIN_PIXELS`=64 after a valid frame -> valid=0; coordinates keep the prior values; `update` still pulses.
- `enable` low for the whole frame with mask all-ones -> valid=0 at T+60.
- Hits only at (0,0) and (639,479) -> centroid (319,239); bbox full frame.
- `rst` asserted at T+20 -> no `update`; all outputs 0; the next frame processes normally.
- Forced frame end at T+30 -> `overrun`=1; the first result still publishes at T+60.
